mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single main-memory data port between the instruction-fetch requester and the memory-stage requester. Forwards one request per cycle with fixed priority to the memory stage, and records the owner of every in-flight transaction in an owner FIFO. Routes in-order memory responses back to the owning requester. Discards fetch responses invalidated by a pipeline flush. Sits between the fetch unit / memory stage and the memory-system data port.

## Interface
- `MAX_OUTSTANDING`, default 4: owner-FIFO depth, i.e. the maximum number of in-flight transactions. Power of 2, ≥2.
- `clk` in 1: clock. All state changes on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `if_req_i` in 1: fetch read request.
- `if_addr_i` in 64: fetch address.
- `if_ready_o` out 1: fetch request accepted this cycle.
- `if_resp_valid_o` out 1: fetch response valid.
- `if_rd_data_o` out 64: fetch read data.
- `dm_req_i` in 1: memory-stage request. Single-cycle pulse, qualified by `dm_ready_o`.
- `dm_addr_i` in 64: memory-stage address.
- `dm_wr_i` in 1: memory-stage write (1) or read (0).
- `dm_wr_data_i` in 64: memory-stage store data, already aligned.
- `dm_mask_i` in 8: memory-stage byte mask.
- `dm_ready_o` out 1: memory stage may issue.
- `dm_resp_valid_o` out 1: memory-stage response valid (reads and writes).
- `dm_rd_data_o` out 64: memory-stage read data.
- `mem_ready_i` in 1: downstream accepts a request.
- `mem_req_o` out 1: downstream request.
- `mem_addr_o` out 64: downstream address.
- `mem_wr_o` out 1: downstream write.
- `mem_wr_data_o` out 64: downstream store data.
- `mem_mask_o` out 8: downstream byte mask.
- `mem_resp_valid_i` in 1: downstream response. One response per request, in order, reads and writes.
- `mem_rd_data_i` in 64: downstream read data.
- `mem_rd_ready_o` out 1: always 1.
- `flush_i` in 1: pipeline flush. Invalidates all in-flight fetch transactions.
- `proto_err_o` out 1: sticky error flag. Set when a response arrives while the owner FIFO is empty.

## Operation
- **State:**
  - Owner FIFO with `MAX_OUTSTANDING` entries, each `{owner: 0=IF, 1=DM; discard}`.
  - Read pointer, write pointer, and `count` of width log2(MAX)+1.
  - `proto_err` flag.
- **Full** means `count == MAX_OUTSTANDING`. Readiness uses only the registered `count`; a pop in the same cycle does not bypass it.
- **Ready signals:**
  - `dm_ready_o = mem_ready_i & ~full`.
  - `if_ready_o = mem_ready_i & ~full & ~dm_req_i & ~flush_i`.
- **Grant:** fixed priority, memory stage first. Fetch waits and holds its request; the memory stage never waits beyond `dm_ready_o`.
- **DM accept** (`dm_req_i & dm_ready_o`):
  - `mem_req_o = 1`; addr, wr, wr_data and mask come from `dm_*`.
  - Push `{1, 0}`.
- **IF accept** (`if_req_i & if_ready_o`):
  - `mem_req_o = 1`, `mem_wr_o = 0`, `mem_wr_data_o = 0`, `mem_mask_o = 0`, `mem_addr_o = if_addr_i`.
  - Push `{0, 0}`.
- **No accept:** all `mem_*` request outputs are 0.
- **Response** (`mem_resp_valid_i`, FIFO not empty):
  - Pop the head entry.
  - Head owner DM: `dm_resp_valid_o = 1`.
  - Head owner IF and not discarded: `if_resp_valid_o = 1`.
  - Discarded IF entry: popped silently, no output.
  - Both `*_rd_data_o` always equal `mem_rd_data_i`.
- **Response with FIFO empty:** dropped; `proto_err_o` set until reset.
- **Flush:**
  - Sets `discard` on every valid IF entry, including a head being popped in the same cycle. That popped response is suppressed.
  - DM entries are unaffected.
  - No IF request is accepted during a flush cycle.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance. Pointers wrap modulo `MAX_OUTSTANDING`.

## Timing
- **Request path:** combinational, 0 cycles from `*_req_i` to `mem_req_o`.
- **Response path:** combinational, 0 cycles from `mem_resp_valid_i` to `*_resp_valid_o`.
- **Register updates:** FIFO, `count` and `discard` bits update on the clock edge after the push, pop or flush.
- **Reset** (async, `resetn=0`):
  - Pointers = 0, `count` = 0, all entries invalid, `proto_err_o` = 0.
  - With the FIFO empty, all outputs are 0 except `mem_rd_ready_o` = 1 and the ready signals, which follow `mem_ready_i`.
  - Reset mid-operation abandons in-flight transactions; a later stray response sets `proto_err_o`.
- **Throughput:** 1 request per cycle while not full; one response per cycle.

## Test plan
1. **Simultaneous requests.** `mem_ready_i=1`, `if_req_i=1`, `dm_req_i=1`, `dm_addr=0x8000_0010` → `mem_addr_o=0x8000_0010`, `if_ready_o=0`. Next cycle, `dm_req_i=0` → fetch is forwarded. Responses `0xAA`, `0xBB` → `dm_resp_valid_o` then `if_resp_valid_o`, with `dm_rd_data_o=0xAA` and `if_rd_data_o=0xBB`.
2. **Fill and wrap.** Issue 4 fetches (MAX=4) → `count=4`, both ready signals 0. Return one response → ready signals 1 next cycle. Run 10 more push/pop pairs → pointer wrap, in-order delivery.
3. **Flush.** 3 fetches and 1 DM write outstanding, order IF, DM, IF, IF. Pulse `flush_i` → only the 2nd response produces `dm_resp_valid_o`; the 3 fetch responses produce no `if_resp_valid_o`. `count` returns to 0.
4. **Flush coinciding with pop and request.** `flush_i=1` in the same cycle as an IF-head response and `if_req_i=1` → `if_resp_valid_o=0`, `if_ready_o=0`, no push.
5. **Protocol error and reset.** `mem_resp_valid_i=1` with the FIFO empty → `proto_err_o=1` and stays high. Assert `resetn=0` mid-traffic → `count=0`, `proto_err_o=0` immediately.
6. **Store passthrough.** DM write of `0x1122_3344_5566_7788`, mask `0x0F` → `mem_wr_o=1`, same data and mask on `mem_*` in the same cycle. Write response → `dm_resp_valid_o=1`.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch, memory-stage, memory-system and flush/error signals of the port arbiter.
// Latency: wiring only; all timing is set by mem_port_arbiter.
// Backpressure: if_ready_o / dm_ready_o gate the requesters; mem_ready_i gates the arbiter.
interface mem_port_arbiter_if;
  // fetch requester
  logic        if_req_i;
  logic [63:0] if_addr_i;
  logic        if_ready_o;
  logic        if_resp_valid_o;
  logic [63:0] if_rd_data_o;
  // memory-stage requester
  logic        dm_req_i;
  logic [63:0] dm_addr_i;
  logic        dm_wr_i;
  logic [63:0] dm_wr_data_i;
  logic [7:0]  dm_mask_i;
  logic        dm_ready_o;
  logic        dm_resp_valid_o;
  logic [63:0] dm_rd_data_o;
  // memory-system data port
  logic        mem_ready_i;
  logic        mem_req_o;
  logic [63:0] mem_addr_o;
  logic        mem_wr_o;
  logic [63:0] mem_wr_data_o;
  logic [7:0]  mem_mask_o;
  logic        mem_resp_valid_i;
  logic [63:0] mem_rd_data_i;
  logic        mem_rd_ready_o;
  // pipeline control / status
  logic        flush_i;
  logic        proto_err_o;

  // arbiter side
  modport slave (
    input  if_req_i, if_addr_i,
    output if_ready_o, if_resp_valid_o, if_rd_data_o,
    input  dm_req_i, dm_addr_i, dm_wr_i, dm_wr_data_i, dm_mask_i,
    output dm_ready_o, dm_resp_valid_o, dm_rd_data_o,
    input  mem_ready_i, mem_resp_valid_i, mem_rd_data_i,
    output mem_req_o, mem_addr_o, mem_wr_o, mem_wr_data_o, mem_mask_o, mem_rd_ready_o,
    input  flush_i,
    output proto_err_o
  );

  // requester / memory-system side
  modport master (
    output if_req_i, if_addr_i,
    input  if_ready_o, if_resp_valid_o, if_rd_data_o,
    output dm_req_i, dm_addr_i, dm_wr_i, dm_wr_data_i, dm_mask_i,
    input  dm_ready_o, dm_resp_valid_o, dm_rd_data_o,
    output mem_ready_i, mem_resp_valid_i, mem_rd_data_i,
    input  mem_req_o, mem_addr_o, mem_wr_o, mem_wr_data_o, mem_mask_o, mem_rd_ready_o,
    output flush_i,
    input  proto_err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares the memory data port between fetch and memory stage; owner FIFO routes in-order responses back.
// Latency: 0 cycles request->mem_req_o and mem_resp_valid_i->*_resp_valid_o; FIFO state updates on the next edge.
// Backpressure: both requesters stall when mem_ready_i is low or MAX_OUTSTANDING transactions are in flight; memory stage wins ties.
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              resetn,
  mem_port_arbiter_if.slave bus
);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PW:0] MAX_CNT = (PW + 1)'(MAX_OUTSTANDING);
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  typedef struct packed {
    logic vld;
    logic owner;
    logic discard;
  } owner_ent_t;

  owner_ent_t    ent_q [MAX_OUTSTANDING];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW:0]   count;
  logic          proto_err_q;

  logic       full, empty;
  logic       dm_rdy, if_rdy;
  logic       dm_acc, if_acc, push, pop;
  owner_ent_t head;

  // readiness looks only at the registered occupancy, so a same-cycle pop never frees a slot early
  assign full   = (count == MAX_CNT);
  assign empty  = (count == '0);
  assign dm_rdy = bus.mem_ready_i & ~full;
  assign if_rdy = bus.mem_ready_i & ~full & ~bus.dm_req_i & ~bus.flush_i;
  assign dm_acc = bus.dm_req_i & dm_rdy;
  assign if_acc = bus.if_req_i & if_rdy;
  assign push   = dm_acc | if_acc;
  assign pop    = bus.mem_resp_valid_i & ~empty;
  assign head   = ent_q[rd_ptr_q];

  assign bus.dm_ready_o = dm_rdy;
  assign bus.if_ready_o = if_rdy;

  // request mux: memory stage has priority; an idle port drives all zeros
  always_comb begin
    bus.mem_req_o     = 1'b0;
    bus.mem_addr_o    = '0;
    bus.mem_wr_o      = 1'b0;
    bus.mem_wr_data_o = '0;
    bus.mem_mask_o    = '0;
    if (dm_acc) begin
      bus.mem_req_o     = 1'b1;
      bus.mem_addr_o    = bus.dm_addr_i;
      bus.mem_wr_o      = bus.dm_wr_i;
      bus.mem_wr_data_o = bus.dm_wr_data_i;
      bus.mem_mask_o    = bus.dm_mask_i;
    end else if (if_acc) begin
      bus.mem_req_o  = 1'b1;
      bus.mem_addr_o = bus.if_addr_i;
    end
  end

  // response routing: a flush in the popping cycle also kills an IF head
  assign bus.dm_resp_valid_o = pop & (head.owner == OWNER_DM);
  assign bus.if_resp_valid_o = pop & (head.owner == OWNER_IF) & ~head.discard & ~bus.flush_i;
  assign bus.dm_rd_data_o    = bus.mem_rd_data_i;
  assign bus.if_rd_data_o    = bus.mem_rd_data_i;
  assign bus.mem_rd_ready_o  = 1'b1;
  assign bus.proto_err_o     = proto_err_q;

  // pointers, occupancy and the sticky protocol-error flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.mem_resp_valid_i && empty) proto_err_q <= 1'b1;
    end
  end

  // owner entries: pop invalidates, flush marks IF entries discarded, push writes a fresh entry
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (pop && (rd_ptr_q == PW'(i))) ent_q[i].vld <= 1'b0;
        if (bus.flush_i && ent_q[i].vld && (ent_q[i].owner == OWNER_IF)) ent_q[i].discard <= 1'b1;
        // a flush cycle can only push a DM entry, so the fresh write never needs the discard bit
        if (push && (wr_ptr_q == PW'(i))) begin
          ent_q[i].vld     <= 1'b1;
          ent_q[i].owner   <= dm_acc ? OWNER_DM : OWNER_IF;
          ent_q[i].discard <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: checks mem_port_arbiter against a queue-based model of in-flight owners, plus fixed-value scenarios.
// Latency: inputs change just after a rising edge; outputs are compared 1 time unit later, well before the next edge.
// Backpressure: mem_ready_i is randomised so both full and not-ready stalls are covered.
module tb_mem_port_arbiter;
  localparam int MAX = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter #(.MAX_OUTSTANDING(MAX)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int tests = 0;
  int fails = 0;

  // model: owner of each in-flight transaction (1 = DM) and whether a flush killed it
  bit m_own[$];
  bit m_disc[$];
  bit m_perr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own.delete();
    m_disc.delete();
    m_perr = 1'b0;
  endtask

  // compare the current cycle's outputs against the model, then advance the model past the coming edge
  task automatic eval_cycle();
    int n;
    bit full, e_dmr, e_ifr, dacc, iacc, pop, e_dmv, e_ifv, e_wr;
    logic [63:0] e_addr, e_wd;
    logic [7:0] e_mask;
    #1;
    n = m_own.size();
    chk("count", 64'(dut.count), 64'(n));
    full  = (n == MAX);
    e_dmr = bus.mem_ready_i && !full;
    e_ifr = bus.mem_ready_i && !full && !bus.dm_req_i && !bus.flush_i;
    dacc  = bus.dm_req_i && e_dmr;
    iacc  = bus.if_req_i && e_ifr;
    e_addr = dacc ? bus.dm_addr_i : (iacc ? bus.if_addr_i : 64'd0);
    e_wr   = dacc && bus.dm_wr_i;
    e_wd   = dacc ? bus.dm_wr_data_i : 64'd0;
    e_mask = dacc ? bus.dm_mask_i : 8'd0;
    pop    = bus.mem_resp_valid_i && (n > 0);
    e_dmv  = pop && m_own[0];
    e_ifv  = pop && !m_own[0] && !m_disc[0] && !bus.flush_i;
    chk("dm_ready", 64'(bus.dm_ready_o), 64'(e_dmr));
    chk("if_ready", 64'(bus.if_ready_o), 64'(e_ifr));
    chk("mem_req", 64'(bus.mem_req_o), 64'(dacc || iacc));
    chk("mem_addr", bus.mem_addr_o, e_addr);
    chk("mem_wr", 64'(bus.mem_wr_o), 64'(e_wr));
    chk("mem_wr_data", bus.mem_wr_data_o, e_wd);
    chk("mem_mask", 64'(bus.mem_mask_o), 64'(e_mask));
    chk("dm_resp_valid", 64'(bus.dm_resp_valid_o), 64'(e_dmv));
    chk("if_resp_valid", 64'(bus.if_resp_valid_o), 64'(e_ifv));
    chk("dm_rd_data", bus.dm_rd_data_o, bus.mem_rd_data_i);
    chk("if_rd_data", bus.if_rd_data_o, bus.mem_rd_data_i);
    chk("mem_rd_ready", 64'(bus.mem_rd_ready_o), 64'd1);
    chk("proto_err", 64'(bus.proto_err_o), 64'(m_perr));
    if (bus.mem_resp_valid_i && n == 0) m_perr = 1'b1;
    if (pop) begin
      void'(m_own.pop_front());
      void'(m_disc.pop_front());
    end
    if (bus.flush_i)
      for (int i = 0; i < m_own.size(); i++) if (!m_own[i]) m_disc[i] = 1'b1;
    if (dacc) begin m_own.push_back(1'b1); m_disc.push_back(1'b0); end
    if (iacc) begin m_own.push_back(1'b0); m_disc.push_back(1'b0); end
  endtask

  task automatic drive(input bit ireq, input logic [63:0] iaddr, input bit dreq, input logic [63:0] daddr,
                       input bit dwr, input logic [63:0] dwd, input logic [7:0] dmask, input bit mrdy,
                       input bit rvld, input logic [63:0] rdat, input bit fl);
    bus.if_req_i         = ireq;
    bus.if_addr_i        = iaddr;
    bus.dm_req_i         = dreq;
    bus.dm_addr_i        = daddr;
    bus.dm_wr_i          = dwr;
    bus.dm_wr_data_i     = dwd;
    bus.dm_mask_i        = dmask;
    bus.mem_ready_i      = mrdy;
    bus.mem_resp_valid_i = rvld;
    bus.mem_rd_data_i    = rdat;
    bus.flush_i          = fl;
    eval_cycle();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
  endtask

  task automatic rand_cycles(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      drive($urandom_range(1, 0), {$urandom, $urandom}, ($urandom_range(2, 0) == 0), {$urandom, $urandom},
            $urandom_range(1, 0), {$urandom, $urandom}, 8'($urandom), ($urandom_range(3, 0) != 0),
            (m_own.size() > 0) && ($urandom_range(1, 0) == 1), {$urandom, $urandom},
            ($urandom_range(15, 0) == 0));
      tick();
    end
  endtask

  initial begin
    resetn = 1'b0;
    bus.if_req_i = 0; bus.if_addr_i = 0; bus.dm_req_i = 0; bus.dm_addr_i = 0; bus.dm_wr_i = 0;
    bus.dm_wr_data_i = 0; bus.dm_mask_i = 0; bus.mem_ready_i = 0; bus.mem_resp_valid_i = 0;
    bus.mem_rd_data_i = 0; bus.flush_i = 0;
    #2;
    // reset state: everything low except mem_rd_ready; readies follow mem_ready_i
    chk("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
    chk("rst_dm_ready", 64'(bus.dm_ready_o), 64'd0);
    chk("rst_proto_err", 64'(bus.proto_err_o), 64'd0);
    chk("rst_mem_rd_ready", 64'(bus.mem_rd_ready_o), 64'd1);
    chk("rst_count", 64'(dut.count), 64'd0);
    bus.mem_ready_i = 1;
    #1;
    chk("rst_dm_ready_follow", 64'(bus.dm_ready_o), 64'd1);
    chk("rst_if_ready_follow", 64'(bus.if_ready_o), 64'd1);
    resetn = 1'b1;
    model_reset();
    tick();

    // simultaneous requests: DM wins, fetch follows; responses return in order
    drive(1, 64'h1000, 1, 64'h8000_0010, 0, 0, 0, 1, 0, 0, 0);
    chk("t1_mem_addr_dm", bus.mem_addr_o, 64'h8000_0010);
    chk("t1_if_ready_blocked", 64'(bus.if_ready_o), 64'd0);
    tick();
    drive(1, 64'h1000, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("t1_mem_addr_if", bus.mem_addr_o, 64'h1000);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'hAA, 0);
    chk("t1_dm_resp", 64'(bus.dm_resp_valid_o), 64'd1);
    chk("t1_dm_data", bus.dm_rd_data_o, 64'hAA);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'hBB, 0);
    chk("t1_if_resp", 64'(bus.if_resp_valid_o), 64'd1);
    chk("t1_if_data", bus.if_rd_data_o, 64'hBB);
    tick();

    // fill and wrap
    for (int i = 0; i < MAX; i++) begin
      drive(1, 64'h2000 + 64'(i * 8), 0, 0, 0, 0, 0, 1, 0, 0, 0);
      tick();
    end
    drive(1, 64'h3000, 1, 64'h4000, 0, 0, 0, 1, 0, 0, 0);
    chk("t2_full_count", 64'(dut.count), 64'd4);
    chk("t2_full_dm_ready", 64'(bus.dm_ready_o), 64'd0);
    chk("t2_full_if_ready", 64'(bus.if_ready_o), 64'd0);
    tick();
    drive(1, 64'h3000, 0, 0, 0, 0, 0, 1, 1, 64'h11, 0);
    chk("t2_pop_no_bypass", 64'(bus.if_ready_o), 64'd0);
    tick();
    drive(1, 64'h3000, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("t2_ready_after_pop", 64'(bus.if_ready_o), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h12, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 64'h5000 + 64'(i), (i % 2) == 1, 64'h6000 + 64'(i), 0, 0, 0, 1, 1, 64'h100 + 64'(i), 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h200 + 64'(i), 0);
      tick();
    end

    // flush with IF, DM, IF, IF outstanding
    drive(1, 64'h7000, 0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 64'h7100, 1, 64'h55, 8'hFF, 1, 0, 0, 0); tick();
    drive(1, 64'h7008, 0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    drive(1, 64'h7010, 0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h300 + 64'(i), 0);
      chk("t3_if_resp_killed", 64'(bus.if_resp_valid_o), 64'd0);
      chk("t3_dm_resp", 64'(bus.dm_resp_valid_o), 64'(i == 1));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("t3_count_empty", 64'(dut.count), 64'd0);
    tick();

    // flush in the same cycle as an IF-head pop and a new fetch request
    drive(1, 64'h8000, 0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    drive(1, 64'h8008, 0, 0, 0, 0, 0, 1, 1, 64'h400, 1);
    chk("t4_if_resp", 64'(bus.if_resp_valid_o), 64'd0);
    chk("t4_if_ready", 64'(bus.if_ready_o), 64'd0);
    chk("t4_no_push", 64'(bus.mem_req_o), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("t4_count", 64'(dut.count), 64'd0);
    tick();

    // store passthrough
    drive(0, 0, 1, 64'h9000, 1, 64'h1122_3344_5566_7788, 8'h0F, 1, 0, 0, 0);
    chk("t6_mem_wr", 64'(bus.mem_wr_o), 64'd1);
    chk("t6_wr_data", bus.mem_wr_data_o, 64'h1122_3344_5566_7788);
    chk("t6_mask", 64'(bus.mem_mask_o), 64'h0F);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h0, 0);
    chk("t6_dm_resp", 64'(bus.dm_resp_valid_o), 64'd1);
    tick();

    rand_cycles(2000);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, (m_own.size() > 0), 64'h500 + 64'(i), 0);
      tick();
    end

    // protocol error: stray response with nothing in flight
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'hDEAD, 0);
    chk("t5_stray_no_resp", 64'(bus.dm_resp_valid_o | bus.if_resp_valid_o), 64'd0);
    tick();
    idle_cycle();
    chk("t5_proto_err_set", 64'(bus.proto_err_o), 64'd1);
    rand_cycles(200);
    chk("t5_proto_err_sticky", 64'(bus.proto_err_o), 64'd1);

    // reset mid-traffic clears everything at once
    resetn = 1'b0;
    #1;
    chk("t5_rst_count", 64'(dut.count), 64'd0);
    chk("t5_rst_proto_err", 64'(bus.proto_err_o), 64'd0);
    model_reset();
    #1;
    resetn = 1'b1;
    rand_cycles(500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
